// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared state encoding, segment patterns and constants for the reaction game
package reaction_game_pkg;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, HOLD, GO, RESULT, DISQ} state_t;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_I     = 7'b1001111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [9:0] MAX_MS = 10'd999;
endpackage

// File: rtl/reaction_game_seg7.sv
// reaction_game_seg7: BCD digit (bcd) to active-low {g..a} segments (seg); 10..15 blank
module reaction_game_seg7
  import reaction_game_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: reaction-time game sequencer (countdown, random hold-off, GO timing, result / disqualify display)
// Ports: clk, reset_n (async active-low); msec_tick 1 ms pulse; start request; button_n raw button, low = pressed;
//        ledg countdown/GO LEDs; result_ms + result_valid last time; disq early press; best_ms best time;
//        hex2..hex0 active-low segments {g..a}, hex2 most significant.
// Macro REACTION_GAME_BEST_EN builds the best-time register; without it best_ms is tied to 999.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int          COUNT_STEPS = 4,
  parameter int          STEP_MS     = 1000,
  parameter int          RAND_MIN_MS = 500,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       msec_tick,
  input  logic       start,
  input  logic       button_n,
  output logic [7:0] ledg,
  output logic [9:0] result_ms,
  output logic       result_valid,
  output logic       disq,
  output logic [9:0] best_ms,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);
  localparam logic [7:0] THERMO_INIT = 8'((1 << COUNT_STEPS) - 1);
  localparam logic [9:0] STEP_LAST   = 10'(STEP_MS - 1);
  state_t      state;
  logic        b_s1, b_s2, b_prev, press_evt;
  logic [15:0] lfsr, hold;
  logic [7:0]  thermo;
  logic [9:0]  step_cnt, cnt;
  logic [3:0]  d2, d1, d0;
  logic [6:0]  seg2, seg1, seg0;
  reaction_game_seg7 u_seg2 (.bcd(d2), .seg(seg2));
  reaction_game_seg7 u_seg1 (.bcd(d1), .seg(seg1));
  reaction_game_seg7 u_seg0 (.bcd(d0), .seg(seg0));
`ifndef REACTION_GAME_BEST_EN
  assign best_ms = MAX_MS;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      b_s1         <= 1'b1;
      b_s2         <= 1'b1;
      b_prev       <= 1'b1;
      press_evt    <= 1'b0;
      lfsr         <= LFSR_SEED;
      hold         <= '0;
      thermo       <= '0;
      step_cnt     <= '0;
      cnt          <= '0;
      {d2, d1, d0} <= '0;
      ledg         <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      disq         <= 1'b0;
      hex2         <= SEG_DASH;
      hex1         <= SEG_DASH;
      hex0         <= SEG_DASH;
`ifdef REACTION_GAME_BEST_EN
      best_ms      <= MAX_MS;
`endif
    end else begin
      b_s1      <= button_n;
      b_s2      <= b_s1;
      b_prev    <= b_s2;
      press_evt <= b_prev & ~b_s2;
      lfsr      <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
      unique case (state)
        IDLE, RESULT, DISQ: begin
          if (start) begin
            state    <= COUNTDOWN;
            thermo   <= THERMO_INIT;
            step_cnt <= '0;
          end
        end
        COUNTDOWN: begin
          if (press_evt) state <= DISQ;
          else if (msec_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              thermo   <= thermo >> 1;
              if (thermo == 8'd1) begin
                hold  <= 16'(RAND_MIN_MS) + 16'(lfsr[9:0]);
                state <= HOLD;
              end
            end else step_cnt <= step_cnt + 10'd1;
          end
        end
        HOLD: begin
          if (press_evt) state <= DISQ;
          else if (hold == 16'd0 || (msec_tick && hold == 16'd1)) begin
            state        <= GO;
            cnt          <= '0;
            {d2, d1, d0} <= '0;
          end else if (msec_tick) hold <= hold - 16'd1;
        end
        GO: begin
          if (press_evt) begin
            state     <= RESULT;
            result_ms <= cnt;
`ifdef REACTION_GAME_BEST_EN
            if (cnt < best_ms) best_ms <= cnt;
`endif
          end else if (msec_tick) begin
            cnt <= cnt + 10'd1;
            d0  <= d0 == 4'd9 ? 4'd0 : d0 + 4'd1;
            d1  <= d0 != 4'd9 ? d1 : d1 == 4'd9 ? 4'd0 : d1 + 4'd1;
            d2  <= (d0 == 4'd9 && d1 == 4'd9) ? d2 + 4'd1 : d2;
            if (cnt == MAX_MS - 10'd1) begin
              state     <= RESULT;
              result_ms <= MAX_MS;
            end
          end
        end
        default: state <= IDLE;
      endcase
      ledg         <= state == COUNTDOWN ? thermo : state == GO ? 8'hFF : 8'h00;
      result_valid <= state == RESULT;
      disq         <= state == DISQ;
      hex2         <= state == RESULT ? seg2 : state == DISQ ? SEG_D : SEG_DASH;
      hex1         <= state == RESULT ? seg1 : state == DISQ ? SEG_I : SEG_DASH;
      hex0         <= state == RESULT ? seg0 : state == DISQ ? SEG_S : SEG_DASH;
    end
  end
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: directed self-checking bench for reaction_game_ctrl
module tb_reaction_game_ctrl;
  localparam int STEPS = 4;
  localparam int STEP  = 2;
  localparam int RMIN  = 5;
`ifdef REACTION_GAME_BEST_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif
  logic       clk, reset_n, msec_tick, start, button_n;
  logic [7:0] ledg;
  logic [9:0] result_ms, best_ms;
  logic       result_valid, disq;
  logic [6:0] hex2, hex1, hex0;
  logic [15:0] m_lfsr, tick_lfsr;
  int n_cmp = 0;
  int n_err = 0;
  reaction_game_ctrl #(.COUNT_STEPS(STEPS), .STEP_MS(STEP), .RAND_MIN_MS(RMIN), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .msec_tick(msec_tick), .start(start), .button_n(button_n),
    .ledg(ledg), .result_ms(result_ms), .result_valid(result_valid), .disq(disq), .best_ms(best_ms),
    .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_lfsr = m_lfsr;
      msec_tick = 1'b1;
      @(negedge clk);
      msec_tick = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask
  task automatic press();
    @(negedge clk);
    button_n = 1'b0;
    repeat (6) @(negedge clk);
    button_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic press_tick();
    @(negedge clk);
    button_n = 1'b0;
    repeat (3) @(negedge clk);
    msec_tick = 1'b1;
    @(negedge clk);
    msec_tick = 1'b0;
    repeat (3) @(negedge clk);
    button_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic run_to_go();
    int h;
    do_start();
    tick_n(STEPS * STEP);
    h = RMIN + int'(tick_lfsr[9:0]);
    tick_n(h - 1);
    chk("hold_wait", 16'(ledg), 16'h00);
    tick_n(1);
    chk("go_led", 16'(ledg), 16'hFF);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int h;
    reset_n = 1'b0;
    msec_tick = 1'b0;
    start = 1'b0;
    button_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ledg", 16'(ledg), 16'h00);
    chk("rst_result", 16'(result_ms), 16'd0);
    chk("rst_valid", 16'(result_valid), 16'd0);
    chk("rst_disq", 16'(disq), 16'd0);
    chk("rst_best", 16'(best_ms), 16'd999);
    chk("rst_hex2", 16'(hex2), 16'h3F);
    chk("rst_hex1", 16'(hex1), 16'h3F);
    chk("rst_hex0", 16'(hex0), 16'h3F);
    do_start();
    chk("cd_0f", 16'(ledg), 16'h0F);
    tick_n(STEP);
    chk("cd_07", 16'(ledg), 16'h07);
    tick_n(STEP);
    chk("cd_03", 16'(ledg), 16'h03);
    tick_n(STEP);
    chk("cd_01", 16'(ledg), 16'h01);
    tick_n(STEP);
    chk("cd_00", 16'(ledg), 16'h00);
    h = RMIN + int'(tick_lfsr[9:0]);
    tick_n(h - 1);
    chk("hold_last", 16'(ledg), 16'h00);
    tick_n(1);
    chk("go_ff", 16'(ledg), 16'hFF);
    tick_n(137);
    do_start();
    chk("go_start_ign", 16'(ledg), 16'hFF);
    press();
    chk("r137_ms", 16'(result_ms), 16'd137);
    chk("r137_hex2", 16'(hex2), 16'h79);
    chk("r137_hex1", 16'(hex1), 16'h30);
    chk("r137_hex0", 16'(hex0), 16'h78);
    chk("r137_valid", 16'(result_valid), 16'd1);
    chk("r137_ledg", 16'(ledg), 16'h00);
    chk("r137_best", 16'(best_ms), BEST ? 16'd137 : 16'd999);
    press();
    chk("res_press_ign", 16'(result_ms), 16'd137);
    chk("res_valid_hold", 16'(result_valid), 16'd1);
    do_start();
    tick_n(STEPS * STEP);
    tick_n(3);
    press();
    chk("dq_disq", 16'(disq), 16'd1);
    chk("dq_hex2", 16'(hex2), 16'h21);
    chk("dq_hex1", 16'(hex1), 16'h4F);
    chk("dq_hex0", 16'(hex0), 16'h12);
    chk("dq_result", 16'(result_ms), 16'd137);
    chk("dq_valid", 16'(result_valid), 16'd0);
    press();
    chk("dq_press_ign", 16'(disq), 16'd1);
    do_start();
    chk("dq_restart_led", 16'(ledg), 16'h0F);
    chk("dq_restart_disq", 16'(disq), 16'd0);
    tick_n(STEPS * STEP);
    h = RMIN + int'(tick_lfsr[9:0]);
    tick_n(h - 1);
    press_tick();
    chk("dq_final_tick", 16'(disq), 16'd1);
    chk("dq_final_led", 16'(ledg), 16'h00);
    run_to_go();
    tick_n(998);
    chk("to_998_valid", 16'(result_valid), 16'd0);
    tick_n(1);
    chk("to_ms", 16'(result_ms), 16'd999);
    chk("to_valid", 16'(result_valid), 16'd1);
    chk("to_hex2", 16'(hex2), 16'h10);
    chk("to_hex1", 16'(hex1), 16'h10);
    chk("to_hex0", 16'(hex0), 16'h10);
    chk("to_best", 16'(best_ms), BEST ? 16'd137 : 16'd999);
    run_to_go();
    tick_n(42);
    press_tick();
    chk("race42_ms", 16'(result_ms), 16'd42);
    chk("race42_hex2", 16'(hex2), 16'h40);
    chk("race42_hex1", 16'(hex1), 16'h19);
    chk("race42_hex0", 16'(hex0), 16'h24);
    chk("race42_best", 16'(best_ms), BEST ? 16'd42 : 16'd999);
    run_to_go();
    tick_n(10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ledg", 16'(ledg), 16'h00);
    chk("mid_rst_hex1", 16'(hex1), 16'h3F);
    chk("mid_rst_result", 16'(result_ms), 16'd0);
    chk("mid_rst_best", 16'(best_ms), 16'd999);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_to_go();
    tick_n(300);
    press();
    chk("b300_ms", 16'(result_ms), 16'd300);
    run_to_go();
    tick_n(250);
    press();
    chk("b250_ms", 16'(result_ms), 16'd250);
    run_to_go();
    tick_n(400);
    press();
    chk("b400_ms", 16'(result_ms), 16'd400);
    chk("best_final", 16'(best_ms), BEST ? 16'd250 : 16'd999);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
